// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owner and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational chooser: dcache has priority unless the icache has waited
// through STARVE_LIMIT consecutive dcache grants. Write-back beats refill.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_req,
  input  logic       d_rd,
  input  logic       d_wr,
  input  logic [3:0] starve_cnt,
  output arb_owner_t owner,
  output logic       is_write
);

  logic d_req;
  logic i_forced;

  always_comb begin
    d_req    = d_rd | d_wr;
    i_forced = i_req && (starve_cnt == 4'(STARVE_LIMIT));
    owner    = OWN_NONE;
    is_write = 1'b0;
    if (d_req && !i_forced) begin
      owner    = OWN_D;
      is_write = d_wr;
    end else if (i_req) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between icache refills and dcache refill/write-back,
// presenting each cache with its own busywait-style port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int BLOCK_W      = BLOCK_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_mem_read,
  input  logic [ADDR_W-1:0]  i_mem_address,
  output logic [BLOCK_W-1:0] i_mem_readdata,
  output logic               i_mem_busywait,
  input  logic               d_mem_read,
  input  logic               d_mem_write,
  input  logic [ADDR_W-1:0]  d_mem_address,
  input  logic [BLOCK_W-1:0] d_mem_writedata,
  output logic [BLOCK_W-1:0] d_mem_readdata,
  output logic               d_mem_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic               grant_i,
  output logic               grant_d
);

  arb_state_t         state;
  arb_owner_t         owner;
  arb_owner_t         pick_owner;
  logic               pick_write;
  logic               cmd_rd;
  logic               cmd_wr;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [3:0]         starve_cnt;
  logic               any_req;
  logic               done;
  logic               cmd_phase;

  assign any_req   = i_mem_read | d_mem_read | d_mem_write;
  assign done      = (state == ST_WAIT) && !mem_busywait;
  assign cmd_phase = (state == ST_ISSUE) || ((state == ST_WAIT) && mem_busywait);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req      (i_mem_read),
    .d_rd       (d_mem_read),
    .d_wr       (d_mem_write),
    .starve_cnt (starve_cnt),
    .owner      (pick_owner),
    .is_write   (pick_write)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner   <= pick_owner;
            cmd_wr  <= pick_write;
            cmd_rd  <= !pick_write;
            addr_q  <= (pick_owner == OWN_I) ? i_mem_address : d_mem_address;
            wdata_q <= pick_write ? d_mem_writedata : '0;
            state   <= ST_ISSUE;
          end
          // Only consecutive dcache wins over a waiting icache count toward starvation.
          if ((pick_owner == OWN_I) || !i_mem_read) begin
            starve_cnt <= '0;
          end else if ((pick_owner == OWN_D) && (starve_cnt < 4'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!mem_busywait) begin
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          owner <= OWN_NONE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_read       = cmd_rd && cmd_phase;
  assign mem_write      = cmd_wr && cmd_phase;
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;

  assign i_mem_readdata = mem_readdata;
  assign d_mem_readdata = mem_readdata;

  // A requester stalls until its own completion cycle, including while waiting for a grant.
  assign i_mem_busywait = i_mem_read && !((owner == OWN_I) && done);
  assign d_mem_busywait = (d_mem_read || d_mem_write) && !((owner == OWN_D) && done);

  assign grant_i = (state != ST_IDLE) && (owner == OWN_I);
  assign grant_d = (state != ST_IDLE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a busy-counting memory, two cache agents and a
// timing-based reference model checked every cycle, plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;
  localparam int LIMIT   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               i_mem_read = 1'b0;
  logic [ADDR_W-1:0]  i_mem_address = '0;
  logic [BLOCK_W-1:0] i_mem_readdata;
  logic               i_mem_busywait;
  logic               d_mem_read = 1'b0;
  logic               d_mem_write = 1'b0;
  logic [ADDR_W-1:0]  d_mem_address = '0;
  logic [BLOCK_W-1:0] d_mem_writedata = '0;
  logic [BLOCK_W-1:0] d_mem_readdata;
  logic               d_mem_busywait;
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata = '0;
  logic               mem_busywait = 1'b0;
  logic               grant_i;
  logic               grant_d;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_writedata(d_mem_writedata), .d_mem_readdata(d_mem_readdata),
    .d_mem_busywait(d_mem_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory latency comes from the top address bits so directed tests can pick it.
  function automatic int lat_of(input logic [ADDR_W-1:0] a);
    return int'(a[27:25]) + 1;
  endfunction

  function automatic logic [BLOCK_W-1:0] fill_value(input logic [ADDR_W-1:0] a);
    return {16{8'hA5}} ^ {120'd0, a[7:0]};
  endfunction

  function automatic logic [10:0] mem_idx(input logic [ADDR_W-1:0] a);
    return {a[27:25], a[7:0]};
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return {3'($urandom), 17'd0, 8'($urandom)};
  endfunction

  // Memory: registered busywait held for lat_of(address) cycles after accepting a command.
  logic [BLOCK_W-1:0] mem_store [2048];
  bit                 mem_written [2048];
  logic               mem_active = 1'b0;
  int                 mem_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_active   <= 1'b0;
      mem_busywait <= 1'b0;
      mem_cnt      <= 0;
    end else if (mem_active) begin
      if (mem_cnt > 0) begin
        mem_cnt <= mem_cnt - 1;
      end else begin
        mem_active   <= 1'b0;
        mem_busywait <= 1'b0;
      end
    end else if (mem_read || mem_write) begin
      mem_active   <= 1'b1;
      mem_busywait <= 1'b1;
      mem_cnt      <= lat_of(mem_address) - 1;
      if (mem_write) begin
        mem_store[mem_idx(mem_address)]   <= mem_writedata;
        mem_written[mem_idx(mem_address)] <= 1'b1;
      end else begin
        mem_readdata <= mem_written[mem_idx(mem_address)] ? mem_store[mem_idx(mem_address)]
                                                          : fill_value(mem_address);
      end
    end
  end

  // Reference model: the port is free again three cycles after a completion cycle.
  int                 cyc = 0;
  int                 m_grant = -100;
  int                 m_done = -100;
  int                 m_free = 0;
  int                 m_starve = 0;
  byte                m_own = 0;
  logic               m_wr = 1'b0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [BLOCK_W-1:0] m_wdata = '0;
  logic [BLOCK_W-1:0] m_rdata = '0;
  logic [BLOCK_W-1:0] ref_store [logic [ADDR_W-1:0]];

  byte                obs_log[$];
  logic               obs_wr[$];
  logic               prev_gi = 1'b0;
  logic               prev_gd = 1'b0;
  int                 cnt_rd_hi = 0;
  int                 cnt_ibusy_lo = 0;
  int                 i_done = 0;
  int                 i_issue_cyc = 0;
  int                 d_comp_cyc = 0;
  logic [BLOCK_W-1:0] last_i_rdata = '0;
  logic [BLOCK_W-1:0] last_d_rdata = '0;
  bit                 d_auto = 1'b0;

  task automatic checkOutput(input string tag, input logic [BLOCK_W-1:0] got,
                             input logic [BLOCK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelStep();
    bit d_req;
    cyc++;
    d_req = d_mem_read || d_mem_write;
    if (!reset) begin
      m_own = 0; m_grant = -100; m_done = -100; m_free = 0; m_starve = 0;
    end else if (cyc >= m_free) begin
      if (i_mem_read || d_req) begin
        m_own    = (d_req && !(i_mem_read && m_starve == LIMIT)) ? "D" : "I";
        m_starve = (m_own == "I" || !i_mem_read) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
        m_wr     = (m_own == "D") && d_mem_write;
        m_addr   = (m_own == "I") ? i_mem_address : d_mem_address;
        m_wdata  = d_mem_writedata;
        m_grant  = cyc;
        m_done   = cyc + 1 + lat_of(m_addr);
        m_free   = m_done + 3;
        if (m_wr) ref_store[m_addr] = m_wdata;
        else m_rdata = ref_store.exists(m_addr) ? ref_store[m_addr] : fill_value(m_addr);
      end else begin
        m_starve = 0;
      end
    end
  endtask

  task automatic checkAll();
    bit in_cmd, completion, hold;
    in_cmd     = (cyc >= m_grant) && (cyc < m_done);
    completion = (cyc == m_done);
    hold       = (cyc >= m_grant) && (cyc <= m_done + 1);
    checkOutput("mem_read", mem_read, in_cmd && !m_wr);
    checkOutput("mem_write", mem_write, in_cmd && m_wr);
    checkOutput("grant_i", grant_i, hold && m_own == "I");
    checkOutput("grant_d", grant_d, hold && m_own == "D");
    checkOutput("i_busywait", i_mem_busywait, i_mem_read && !(completion && m_own == "I"));
    checkOutput("d_busywait", d_mem_busywait,
                (d_mem_read || d_mem_write) && !(completion && m_own == "D"));
    if (in_cmd) checkOutput("mem_address", mem_address, m_addr);
    if (in_cmd && m_wr) checkOutput("mem_writedata", mem_writedata, m_wdata);
    if (completion && !m_wr) begin
      if (m_own == "I") checkOutput("i_readdata", i_mem_readdata, m_rdata);
      else checkOutput("d_readdata", d_mem_readdata, m_rdata);
    end
  endtask

  task automatic observe();
    if (grant_i && !prev_gi) begin obs_log.push_back("I"); obs_wr.push_back(mem_write); i_issue_cyc = cyc; end
    if (grant_d && !prev_gd) begin obs_log.push_back("D"); obs_wr.push_back(mem_write); end
    prev_gi = grant_i;
    prev_gd = grant_d;
    if (mem_read) cnt_rd_hi++;
    if (i_mem_read && !i_mem_busywait) cnt_ibusy_lo++;
  endtask

  task automatic newIReq();
    i_mem_address = rand_addr();
    i_mem_read    = 1'b1;
  endtask

  task automatic newDReq();
    int kind;
    kind            = $urandom_range(0, 2);
    d_mem_address   = rand_addr();
    d_mem_writedata = {$urandom, $urandom, $urandom, $urandom};
    d_mem_read      = (kind != 1);
    d_mem_write     = (kind != 0);
  endtask

  // Cache agents: drop a request in its completion cycle; a write-back gives way to its refill.
  task automatic applyStimulus();
    if (i_mem_read && !i_mem_busywait) begin
      last_i_rdata = i_mem_readdata;
      i_mem_read   = 1'b0;
      i_done++;
    end
    if ((d_mem_read || d_mem_write) && !d_mem_busywait) begin
      d_comp_cyc = cyc;
      if (d_mem_write) d_mem_write = 1'b0;
      else begin last_d_rdata = d_mem_readdata; d_mem_read = 1'b0; end
      if (!d_mem_read && !d_mem_write && d_auto) newDReq();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
    observe();
    applyStimulus();
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    int n = 0;
    while ((i_mem_read || d_mem_read || d_mem_write) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checkOutput({tag, "_timeout"}, 1'b1, 1'b0);
      i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic waitGrants(input string tag, input int count, input int budget);
    int n = 0;
    while (obs_log.size() < count && n < budget) begin tick(); n++; end
    if (n >= budget) checkOutput({tag, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic checkSequence(input string tag, input string exp_seq);
    byte got;
    checkOutput({tag, "_count"}, 32'(obs_log.size()), 32'(exp_seq.len()));
    for (int k = 0; k < exp_seq.len(); k++) begin
      got = (k < obs_log.size()) ? obs_log[k] : "?";
      checkOutput($sformatf("%s_grant%0d", tag, k), got, exp_seq[k]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Icache read held through reset, then served with a 5-cycle busy memory.
    i_mem_address = 28'h8000000;
    i_mem_read    = 1'b1;
    repeat (2) tick();
    checkOutput("t1_rst_mem_read", mem_read, 1'b0);
    checkOutput("t1_rst_grant_i", grant_i, 1'b0);
    checkOutput("t1_rst_i_busy", i_mem_busywait, 1'b1);
    cnt_rd_hi = 0; cnt_ibusy_lo = 0;
    reset = 1'b1;
    waitQuiet("t1", 40);
    checkOutput("t1_mem_read_cycles", 32'(cnt_rd_hi), 32'd6);
    checkOutput("t1_i_busy_low_cycles", 32'(cnt_ibusy_lo), 32'd1);
    checkOutput("t1_i_rdata", last_i_rdata, {16{8'hA5}});

    // Simultaneous requests: dcache first, icache after RELEASE and IDLE.
    obs_log.delete(); obs_wr.delete();
    newIReq();
    d_mem_address = rand_addr(); d_mem_read = 1'b1;
    waitQuiet("t2", 80);
    checkSequence("t2", "DI");
    checkOutput("t2_gap", 32'(i_issue_cyc - d_comp_cyc), 32'd3);

    // Write-back and refill of the same block: write first, then read returns the new data.
    obs_log.delete(); obs_wr.delete();
    d_mem_address   = 28'h0000010;
    d_mem_writedata = 128'h12345678_9abcdef0_0fedcba9_87654321;
    d_mem_write     = 1'b1;
    d_mem_read      = 1'b1;
    waitQuiet("t3", 60);
    checkSequence("t3", "DD");
    checkOutput("t3_first_is_write", (obs_wr.size() > 0) ? obs_wr[0] : 1'bx, 1'b1);
    checkOutput("t3_second_is_read", (obs_wr.size() > 1) ? obs_wr[1] : 1'bx, 1'b0);
    checkOutput("t3_d_rdata", last_d_rdata, 128'h12345678_9abcdef0_0fedcba9_87654321);

    // Starvation: back-to-back dcache traffic with the icache waiting.
    obs_log.delete(); obs_wr.delete();
    newIReq(); d_auto = 1'b1; newDReq();
    waitGrants("t4", 6, 300);
    d_auto = 1'b0;
    waitQuiet("t4", 80);
    checkOutput("t4_i_served", 32'(obs_log.size() >= 6), 32'd1);
    if (obs_log.size() > 6) obs_log = obs_log[0:5];
    checkSequence("t4", "DDDDID");

    // Asynchronous reset in the third WAIT cycle of a long write.
    obs_log.delete(); obs_wr.delete();
    d_mem_address = 28'hE000020; d_mem_writedata = {4{$urandom}}; d_mem_write = 1'b1;
    repeat (4) tick();
    checkOutput("t5_pre_mem_write", mem_write, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("t5_async_mem_write", mem_write, 1'b0);
    checkOutput("t5_async_grant_d", grant_d, 1'b0);
    checkOutput("t5_async_d_busy", d_mem_busywait, 1'b1);
    tick();
    reset = 1'b1;
    waitQuiet("t5", 60);
    checkSequence("t5", "DD");
    checkOutput("t5_fresh_is_write", (obs_wr.size() > 1) ? obs_wr[1] : 1'bx, 1'b1);

    // Icache request withdrawn while the dcache is served; the starvation count must clear.
    obs_log.delete(); obs_wr.delete();
    i_done = 0;
    d_mem_address = 28'h6000030; d_mem_read = 1'b1; newIReq();
    repeat (2) tick();
    i_mem_read = 1'b0;
    waitQuiet("t6", 40);
    checkSequence("t6", "D");
    checkOutput("t6_no_i_txn", 32'(i_done), 32'd0);
    obs_log.delete(); obs_wr.delete();
    newIReq(); d_auto = 1'b1; newDReq();
    waitGrants("t6b", 6, 300);
    d_auto = 1'b0;
    waitQuiet("t6b", 80);
    if (obs_log.size() > 6) obs_log = obs_log[0:5];
    checkSequence("t6b", "DDDDID");

    // Random traffic from both caches, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      tick();
      if (!i_mem_read && $urandom_range(0, 3) == 0) newIReq();
      if (!d_mem_read && !d_mem_write && $urandom_range(0, 2) == 0) newDReq();
    end
    waitQuiet("rand", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
